piso_8_bit_tx: RTL
==================

Name: piso_8_bit_tx

Overview:
Parallel-in, serial-out transmitter that drives the serial side of the team's shift-register links.
- Accepts a WIDTH-bit word over a valid/ready handshake.
- Shifts the word out one bit per clock, LSB first by default.
- Flags each active bit with frame_valid and pulses done on the last bit.
- Back-to-back words stream with no idle gap, so a downstream serial-in shift register sees a continuous bitstream.

Parameters:
WIDTH, 8, word width in bits; legal range is 2 or more.
LSB_FIRST, 1, 1 = bit 0 transmitted first; 0 = bit WIDTH-1 transmitted first.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
data_in  input  WIDTH  parallel word to transmit; sampled only on handshake.
load_valid  input  1  producer has a word on data_in.
load_ready  output  1  transmitter can accept a word this cycle.
serial_out  output  1  current serial bit.
frame_valid  output  1  high on every cycle serial_out carries a data bit.
done  output  1  one-cycle pulse during the last bit of a word.

Behaviour:
- Reset: rst_n low forces, immediately and asynchronously:
  - state=IDLE, shift register=0, bit count=0
  - serial_out=0, frame_valid=0, done=0
  - load_ready reads 1, but no handshake is accepted while rst_n is low.
- State machine:
  - Two states, IDLE and SHIFT.
  - Internal WIDTH-bit shift register shreg.
  - Bit counter cnt, width $clog2(WIDTH).
- IDLE:
  - load_ready=1, serial_out=0, frame_valid=0, done=0.
  - On an edge with load_valid&&load_ready: shreg<=data_in, cnt<=0, state goes to SHIFT.
- SHIFT:
  - frame_valid=1.
  - serial_out=shreg[0] if LSB_FIRST, else shreg[WIDTH-1]. It is combinational from registers only, with no path from inputs.
  - Each edge: shreg shifts one place toward the output end, fill bit 0, and cnt increments.
- Last bit (cnt==WIDTH-1):
  - done=1 and load_ready=1 for this cycle only.
  - At the edge: if load_valid, reload shreg<=data_in, cnt<=0, stay in SHIFT (gapless). Otherwise go to IDLE.
- Mid-word (SHIFT, cnt<WIDTH-1): load_ready=0. load_valid and data_in are ignored, and the producer must hold them.
- Latency: a word accepted at edge N puts its first bit on serial_out in the cycle after edge N; its last bit occupies cycle N+WIDTH-1 after that edge. Throughput is 1 word per WIDTH cycles.
- data_in is captured only on the handshake edge. Later changes to data_in never alter the word in flight.
- Reset mid-word: the word is abandoned. All outputs drop within the reset assertion, with no done pulse. After release the block is in IDLE.
- Simultaneous events: load_valid rising in the same cycle as done is accepted, which is the gapless case.

Decomposition:
- Shared package piso_pkg:
  - tx_state_t enum {IDLE, SHIFT}
  - DEFAULT_WIDTH=8
  - CNT_W function/localparam ($clog2)
- Sub-module tx_bit_counter, instantiated once:
  - Ports: clk, rst_n, clear, enable, WIDTH-parameterised.
  - Outputs cnt and last (cnt==WIDTH-1).
- The FSM and shift register remain in piso_8_bit_tx.

Test Plan:
1. Reset: assert rst_n=0 mid-simulation asynchronously (between edges) -> serial_out, frame_valid and done read 0 before the next edge; load_ready=1.
2. Single word: data_in=8'h3C, one-cycle load_valid -> over 8 cycles serial_out=0,0,1,1,1,1,0,0 with frame_valid=1 throughout, done=1 only on the 8th bit, then IDLE (frame_valid=0).
3. Back-to-back: 8'hA5 then 8'h3C, load_valid held high -> 16 contiguous frame_valid cycles, serial_out=1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0; done pulses on cycles 8 and 16; load_ready is high only on those cycles.
4. Mid-word hold: load 8'hFF, then change data_in to 8'h00 with load_valid=1 from cycle 2 -> first word transmits all 1s; 8'h00 is accepted only at the done edge and follows gaplessly.
5. Reset mid-word: load 8'hFF, deassert rst_n at bit 3 -> outputs go to 0 immediately with no done; after release, load 8'h01 -> serial_out=1,0,0,0,0,0,0,0.
6. LSB_FIRST=0: load 8'h01 -> serial_out=0,0,0,0,0,0,0,1 with done on the 8th bit.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the PISO transmitter.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Counter width needed to index WIDTH bits (WIDTH >= 2 keeps this >= 1).
    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/tx_bit_counter.sv
// Bit position counter for the PISO transmitter; flags the final bit of a word.
module tx_bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    // Clear has priority so a gapless reload restarts at bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Terminal-count compare.
    always_comb begin
        last = (cnt == CNT_W'(WIDTH - 1));
    end

endmodule

// File: rtl/piso_8_bit_tx.sv
// Parallel-in serial-out transmitter with valid/ready load and gapless streaming.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no word in flight; ready for a load, serial line parked at 0
//   SHIFT | driving one data bit per cycle; reloads on the last bit
module piso_8_bit_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             frame_valid,
    output logic             done
);

    localparam int CNT_W = cnt_w(WIDTH);

    tx_state_t        state;
    tx_state_t        state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] bit_cnt;
    logic             last;
    logic             accept;
    logic             cnt_clear;

    tx_bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (cnt_clear),
        .enable (state == SHIFT),
        .cnt    (bit_cnt),
        .last   (last)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and outputs; outputs depend on registers only.
    always_comb begin
        state_nxt   = state;
        load_ready  = 1'b0;
        serial_out  = 1'b0;
        frame_valid = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                frame_valid = 1'b1;
                serial_out  = LSB_FIRST ? shreg[0] : shreg[WIDTH-1];
                if (last) begin
                    done       = 1'b1;
                    load_ready = 1'b1;
                    state_nxt  = load_valid ? SHIFT : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        accept    = load_valid && load_ready;
        // Restart the counter on every load and at the end of every word so
        // it always sits at zero while idle.
        cnt_clear = accept || ((state == SHIFT) && last);
    end

    // Shift register: capture on handshake, otherwise shift toward the output end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
        end else if (accept) begin
            shreg <= data_in;
        end else if (state == SHIFT) begin
            if (LSB_FIRST) begin
                shreg <= {1'b0, shreg[WIDTH-1:1]};
            end else begin
                shreg <= {shreg[WIDTH-2:0], 1'b0};
            end
        end
    end

    // The counter must be parked at zero whenever no word is in flight.
    idle_cnt_zero_a : assert property (@(posedge clk) disable iff (!rst_n)
        (state == IDLE) |-> (bit_cnt == '0));

endmodule
